// File: rtl/seq_priority_encoder_if.sv
// Handshake bundle for seq_priority_encoder: load side (ena/data_in) and
// indexed output stream (data_out/out_valid/out_ready) plus status pulses.
interface seq_priority_encoder_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 3
);
  logic             ena;
  logic [WIDTH-1:0] data_in;
  logic             out_ready;
  logic [IDX_W-1:0] data_out;
  logic             out_valid;
  logic             out_last;
  logic             busy;
  logic             done;
  logic             zero_flag;

  modport master (
    output ena, data_in, out_ready,
    input  data_out, out_valid, out_last, busy, done, zero_flag
  );

  modport slave (
    input  ena, data_in, out_ready,
    output data_out, out_valid, out_last, busy, done, zero_flag
  );
endinterface

// File: rtl/seq_priority_encoder.sv
// Sequential priority encoder: loads a multi-hot vector and streams the index
// of each set bit, lowest first, one per valid/ready handshake.
module seq_priority_encoder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_priority_encoder_if.slave bus
);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e           state_q,     state_d;
  logic [WIDTH-1:0] pending_q,   pending_d;
  logic [IDX_W-1:0] data_out_q,  data_out_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q,  out_last_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic             zero_flag_q, zero_flag_d;

  logic [WIDTH-1:0] load_rest;
  logic [WIDTH-1:0] pending_rest;
  logic             handshake;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [WIDTH-1:0] v);
    lowest_idx = '0;
    for (int unsigned i = WIDTH; i > 0; i--) begin
      if (v[i-1]) lowest_idx = IDX_W'(i - 1);
    end
  endfunction

  // pending holds every bit not yet handed off, including the one on data_out;
  // v & (v-1) drops the lowest set bit, so *_rest is what remains after it.
  assign load_rest    = bus.data_in & (bus.data_in - WIDTH'(1));
  assign pending_rest = pending_q & (pending_q - WIDTH'(1));
  assign handshake    = out_valid_q & bus.out_ready;

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    data_out_d  = data_out_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    zero_flag_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.ena) begin
          if (bus.data_in != '0) begin
            state_d     = EMIT;
            pending_d   = bus.data_in;
            data_out_d  = lowest_idx(bus.data_in);
            out_valid_d = 1'b1;
            out_last_d  = (load_rest == '0);
            busy_d      = 1'b1;
          end else begin
            zero_flag_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (handshake) begin
          if (pending_rest != '0) begin
            pending_d  = pending_rest;
            data_out_d = lowest_idx(pending_rest);
            out_last_d = ((pending_rest & (pending_rest - WIDTH'(1))) == '0);
          end else begin
            state_d     = IDLE;
            pending_d   = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      zero_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      zero_flag_q <= zero_flag_d;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.zero_flag = zero_flag_q;

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Self-checking bench for seq_priority_encoder against a queue-of-indices model.
module tb_seq_priority_encoder;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned IDX_W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned errors = 0;
  int unsigned checks = 0;
  int exp_q[$];

  seq_priority_encoder_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus();

  seq_priority_encoder #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: the ascending list of set-bit positions of the loaded vector.
  function automatic void build_model(input logic [WIDTH-1:0] v);
    exp_q.delete();
    for (int i = 0; i < int'(WIDTH); i++) if (v[i]) exp_q.push_back(i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.ena = 1'($urandom); bus.data_in = WIDTH'($urandom); bus.out_ready = 1'($urandom);
    #1;
    checks++;
    if ({bus.data_out, bus.out_valid, bus.out_last, bus.busy, bus.done, bus.zero_flag} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got idx=%0d v=%b l=%b b=%b d=%b z=%b exp all 0",
               bus.data_out, bus.out_valid, bus.out_last, bus.busy, bus.done, bus.zero_flag);
    end
    tick(); tick();
    bus.ena = 1'b0;
    rst_n = 1'b1;
    tick();
    bus.ena = 1'b1; bus.data_in = 8'h10; bus.out_ready = 1'b1;
    tick();
    bus.ena = 1'b0;
    checks++;
    if (bus.data_out !== 3'd4 || bus.out_valid !== 1'b1 || bus.out_last !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL first_load got idx=%0d v=%b l=%b b=%b exp idx=4 v=1 l=1 b=1",
               bus.data_out, bus.out_valid, bus.out_last, bus.busy);
    end
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_done got d=%b b=%b v=%b exp d=1 b=0 v=0", bus.done, bus.busy, bus.out_valid);
    end
    tick();
  endtask

  task automatic test_full_drain();
    int k = 0;
    int n = 0;
    build_model(8'hFF);
    bus.ena = 1'b1; bus.data_in = 8'hFF; bus.out_ready = 1'b1;
    tick();
    bus.ena = 1'b0; bus.data_in = WIDTH'($urandom);
    while (k < exp_q.size() && n < 50) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.data_out !== IDX_W'(exp_q[k]) ||
          bus.out_last !== (k == exp_q.size() - 1) || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL full_drain step=%0d got idx=%0d v=%b l=%b d=%b exp idx=%0d l=%b",
                 k, bus.data_out, bus.out_valid, bus.out_last, bus.done, exp_q[k], k == exp_q.size() - 1);
      end
      tick(); k++; n++;
    end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 ||
        bus.data_out !== 3'd7) begin
      errors++;
      $display("FAIL full_drain_done got d=%b b=%b v=%b l=%b idx=%0d exp d=1 b=0 v=0 l=0 idx=7",
               bus.done, bus.busy, bus.out_valid, bus.out_last, bus.data_out);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL done_width got done=%b exp 0", bus.done);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] pat;
    int k = 0;
    int p = 0;
    int hs = 0;
    pat = 4'b1001;
    build_model(8'hA5);
    bus.ena = 1'b1; bus.data_in = 8'hA5; bus.out_ready = 1'b0;
    tick();
    bus.ena = 1'b0;
    while (k < exp_q.size() && p < 60) begin
      bus.out_ready = pat[3 - (p % 4)];
      checks++;
      if (bus.out_valid !== 1'b1 || bus.data_out !== IDX_W'(exp_q[k]) ||
          bus.out_last !== (k == exp_q.size() - 1)) begin
        errors++;
        $display("FAIL backpressure cyc=%0d got idx=%0d v=%b l=%b exp idx=%0d l=%b",
                 p, bus.data_out, bus.out_valid, bus.out_last, exp_q[k], k == exp_q.size() - 1);
      end
      tick();
      if (bus.out_ready) begin k++; hs++; end
      p++;
    end
    checks++;
    if (hs != 4 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_end got hs=%0d d=%b b=%b exp hs=4 d=1 b=0", hs, bus.done, bus.busy);
    end
    bus.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_zero_vector();
    bus.ena = 1'b1; bus.data_in = '0;
    tick();
    bus.ena = 1'b0;
    checks++;
    if (bus.zero_flag !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL zero_vector got z=%b v=%b b=%b d=%b exp z=1 v=0 b=0 d=0",
               bus.zero_flag, bus.out_valid, bus.busy, bus.done);
    end
    tick();
    checks++;
    if (bus.zero_flag !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_pulse got z=%b v=%b exp z=0 v=0", bus.zero_flag, bus.out_valid);
    end
  endtask

  task automatic test_ignored_load();
    bus.ena = 1'b1; bus.data_in = 8'h81; bus.out_ready = 1'b1;
    tick();
    bus.data_in = 8'h7E;
    checks++;
    if (bus.data_out !== 3'd0 || bus.out_valid !== 1'b1 || bus.out_last !== 1'b0) begin
      errors++;
      $display("FAIL ignored_first got idx=%0d v=%b l=%b exp idx=0 v=1 l=0", bus.data_out, bus.out_valid, bus.out_last);
    end
    tick();
    checks++;
    if (bus.data_out !== 3'd7 || bus.out_valid !== 1'b1 || bus.out_last !== 1'b1) begin
      errors++;
      $display("FAIL ignored_second got idx=%0d v=%b l=%b exp idx=7 v=1 l=1", bus.data_out, bus.out_valid, bus.out_last);
    end
    tick();
    bus.ena = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ignored_done got d=%b b=%b v=%b exp d=1 b=0 v=0", bus.done, bus.busy, bus.out_valid);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL ignored_not_queued got v=%b b=%b d=%b exp v=0 b=0 d=0", bus.out_valid, bus.busy, bus.done);
    end
    bus.ena = 1'b1; bus.data_in = 8'h02;
    tick();
    bus.ena = 1'b0;
    checks++;
    if (bus.data_out !== 3'd1 || bus.out_valid !== 1'b1 || bus.out_last !== 1'b1) begin
      errors++;
      $display("FAIL reload got idx=%0d v=%b l=%b exp idx=1 v=1 l=1", bus.data_out, bus.out_valid, bus.out_last);
    end
    tick();
    tick();
  endtask

  task automatic test_mid_reset();
    bus.ena = 1'b1; bus.data_in = 8'hF0; bus.out_ready = 1'b1;
    tick();
    bus.ena = 1'b0;
    checks++;
    if (bus.data_out !== 3'd4 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_first got idx=%0d v=%b exp idx=4 v=1", bus.data_out, bus.out_valid);
    end
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.data_out, bus.out_valid, bus.out_last, bus.busy, bus.done, bus.zero_flag} !== '0) begin
      errors++;
      $display("FAIL mid_reset_async got idx=%0d v=%b l=%b b=%b d=%b z=%b exp all 0",
               bus.data_out, bus.out_valid, bus.out_last, bus.busy, bus.done, bus.zero_flag);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.done !== 1'b0 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_no_done got d=%b v=%b exp d=0 v=0", bus.done, bus.out_valid);
      end
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle got d=%b v=%b b=%b exp d=0 v=0 b=0", bus.done, bus.out_valid, bus.busy);
    end
    bus.ena = 1'b1; bus.data_in = 8'h01;
    tick();
    bus.ena = 1'b0;
    checks++;
    if (bus.data_out !== 3'd0 || bus.out_valid !== 1'b1 || bus.out_last !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_load got idx=%0d v=%b l=%b exp idx=0 v=1 l=1", bus.data_out, bus.out_valid, bus.out_last);
    end
    tick();
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_done got d=%b exp 1", bus.done);
    end
    tick();
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] v;
    for (int it = 0; it < 30; it++) begin
      int k = 0;
      int n = 0;
      v = WIDTH'($urandom);
      if ($urandom_range(0, 7) == 0) v = '0;
      build_model(v);
      bus.ena = 1'b1; bus.data_in = v; bus.out_ready = 1'($urandom);
      tick();
      bus.ena = 1'b0;
      if (exp_q.size() == 0) begin
        checks++;
        if (bus.zero_flag !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL rand_zero it=%0d got z=%b v=%b b=%b exp z=1 v=0 b=0", it, bus.zero_flag, bus.out_valid, bus.busy);
        end
      end else begin
        while (k < exp_q.size() && n < 200) begin
          bus.out_ready = ($urandom_range(0, 9) < 6);
          bus.ena = 1'($urandom);
          bus.data_in = WIDTH'($urandom);
          checks++;
          if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1 || bus.data_out !== IDX_W'(exp_q[k]) ||
              bus.out_last !== (k == exp_q.size() - 1)) begin
            errors++;
            $display("FAIL rand_drain vec=%h step=%0d got idx=%0d v=%b b=%b l=%b exp idx=%0d l=%b",
                     v, k, bus.data_out, bus.out_valid, bus.busy, bus.out_last, exp_q[k], k == exp_q.size() - 1);
          end
          tick();
          if (bus.out_ready) k++;
          n++;
        end
        bus.ena = 1'b0;
        checks++;
        if (k != exp_q.size() || bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 ||
            bus.data_out !== IDX_W'(exp_q[exp_q.size() - 1])) begin
          errors++;
          $display("FAIL rand_done vec=%h got hs=%0d d=%b b=%b v=%b idx=%0d exp hs=%0d d=1 b=0 v=0 idx=%0d",
                   v, k, bus.done, bus.busy, bus.out_valid, bus.data_out, exp_q.size(), exp_q[exp_q.size() - 1]);
        end
      end
      tick();
      checks++;
      if (bus.done !== 1'b0 || bus.zero_flag !== 1'b0 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rand_idle vec=%h got d=%b z=%b v=%b exp 0 0 0", v, bus.done, bus.zero_flag, bus.out_valid);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bus.ena = 1'b0;
    bus.data_in = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_full_drain();
    test_backpressure();
    test_zero_vector();
    test_ignored_load();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
